// File: rtl/pipe_chain_if.sv
// Bundles the pipe_chain stream, flush, forwarding-lookup and occupancy signals.
// slave is the pipeline side; master is the producer/consumer/decode side.
interface pipe_chain_if #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned RWIDTH = 32,
   parameter int unsigned CW     = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_payload;
   logic              in_rf_we;
   logic [4:0]        in_dest;
   logic [RWIDTH-1:0] in_result;
   logic              in_res_rdy;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_payload;
   logic              out_rf_we;
   logic [4:0]        out_dest;
   logic [RWIDTH-1:0] out_result;
   logic              flush;
   logic [4:0]        raddr1;
   logic [4:0]        raddr2;
   logic              fwd_hit1;
   logic              fwd_hit2;
   logic [RWIDTH-1:0] fwd_data1;
   logic [RWIDTH-1:0] fwd_data2;
   logic              hz_stall;
   logic [CW-1:0]     count;

   modport slave (
      input  in_valid, in_payload, in_rf_we, in_dest, in_result, in_res_rdy,
      input  out_ready, flush, raddr1, raddr2,
      output in_ready, out_valid, out_payload, out_rf_we, out_dest, out_result,
      output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, hz_stall, count
   );

   modport master (
      output in_valid, in_payload, in_rf_we, in_dest, in_result, in_res_rdy,
      output out_ready, flush, raddr1, raddr2,
      input  in_ready, out_valid, out_payload, out_rf_we, out_dest, out_result,
      input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, hz_stall, count
   );
endinterface

// File: rtl/pipe_chain.sv
// In-order pipeline register chain with allow-in backpressure, flush, occupancy
// count and a youngest-first register-hazard forwarding lookup for two read ports.
module pipe_chain #(
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned RWIDTH = 32,
   parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
   input logic       clk,
   input logic       resetn,
   pipe_chain_if.slave bus
);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  we_q, we_d;
   logic [DEPTH-1:0]  rdy_q, rdy_d;
   logic [DEPTH-1:0]  allowin;
   logic [WIDTH-1:0]  payload_q [DEPTH];
   logic [WIDTH-1:0]  payload_d [DEPTH];
   logic [4:0]        dest_q    [DEPTH];
   logic [4:0]        dest_d    [DEPTH];
   logic [RWIDTH-1:0] result_q  [DEPTH];
   logic [RWIDTH-1:0] result_d  [DEPTH];
   logic [CW-1:0]     count_q, count_d;

   logic              in_acc;
   logic              out_xfer;
   logic [4:0]        raddr    [2];
   logic [1:0]        hit;
   logic [1:0]        hit_rdy;
   logic [RWIDTH-1:0] hit_data [2];

   // A stage may load when it is empty or the stage ahead of it can move.
   always_comb begin
      allowin[DEPTH-1] = !valid_q[DEPTH-1] | bus.out_ready;
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         allowin[i] = !valid_q[i] | allowin[i+1];
      end
   end

   assign in_acc   = bus.in_valid & allowin[0] & ~bus.flush;
   assign out_xfer = valid_q[DEPTH-1] & bus.out_ready;

   always_comb begin
      valid_d   = valid_q;
      we_d      = we_q;
      rdy_d     = rdy_q;
      payload_d = payload_q;
      dest_d    = dest_q;
      result_d  = result_q;
      if (allowin[0]) begin
         valid_d[0]   = bus.in_valid;
         we_d[0]      = bus.in_rf_we;
         rdy_d[0]     = bus.in_res_rdy;
         payload_d[0] = bus.in_payload;
         dest_d[0]    = bus.in_dest;
         result_d[0]  = bus.in_result;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
         if (allowin[i]) begin
            valid_d[i]   = valid_q[i-1];
            we_d[i]      = we_q[i-1];
            rdy_d[i]     = rdy_q[i-1];
            payload_d[i] = payload_q[i-1];
            dest_d[i]    = dest_q[i-1];
            result_d[i]  = result_q[i-1];
         end
      end
      if (bus.flush) begin
         valid_d = '0;
      end
   end

   always_comb begin
      if (bus.flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(in_acc) - CW'(out_xfer);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         we_q    <= '0;
         rdy_q   <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            payload_q[i] <= '0;
            dest_q[i]    <= '0;
            result_q[i]  <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         we_q      <= we_d;
         rdy_q     <= rdy_d;
         payload_q <= payload_d;
         dest_q    <= dest_d;
         result_q  <= result_d;
         count_q   <= count_d;
      end
   end

   assign raddr[0] = bus.raddr1;
   assign raddr[1] = bus.raddr2;

   // Scan oldest to youngest so the youngest matching writer wins.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         hit[p]      = 1'b0;
         hit_rdy[p]  = 1'b1;
         hit_data[p] = '0;
         for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (valid_q[i] && we_q[i] && (raddr[p] != 5'd0) && (dest_q[i] == raddr[p])) begin
               hit[p]      = 1'b1;
               hit_rdy[p]  = rdy_q[i];
               hit_data[p] = result_q[i];
            end
         end
      end
   end

   assign bus.in_ready    = allowin[0];
   assign bus.out_valid   = valid_q[DEPTH-1];
   assign bus.out_payload = payload_q[DEPTH-1];
   assign bus.out_rf_we   = we_q[DEPTH-1];
   assign bus.out_dest    = dest_q[DEPTH-1];
   assign bus.out_result  = result_q[DEPTH-1];
   assign bus.fwd_hit1    = hit[0];
   assign bus.fwd_hit2    = hit[1];
   assign bus.fwd_data1   = hit_data[0];
   assign bus.fwd_data2   = hit_data[1];
   assign bus.hz_stall    = (hit[0] & ~hit_rdy[0]) | (hit[1] & ~hit_rdy[1]);
   assign bus.count       = count_q;

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised in-order pipeline register chain with per-stage valid bits and allow-in backpressure.
- Built-in register-hazard scoreboard with operand forwarding.
- Replaces the fixed, never-stalling D-E/E-M/M-W flop groups of the 5-stage core.
- Adds stall, flush, occupancy count and two read-port forwarding lookups for the decode stage.

Parameters:
- DEPTH, 3, number of pipeline stages (>=1); stage 0 is youngest, stage DEPTH-1 is oldest.
- WIDTH, 64, opaque control payload width carried per stage.
- RWIDTH, 32, result/forward data width.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers an instruction.
- in_ready  output  1  stage 0 can accept this cycle.
- in_payload  input  WIDTH  control payload.
- in_rf_we  input  1  instruction writes the register file.
- in_dest  input  5  destination register number.
- in_result  input  RWIDTH  result value, if already known.
- in_res_rdy  input  1  in_result is final (0 for loads).
- out_valid  output  1  oldest stage holds a valid entry.
- out_ready  input  1  downstream consumes the oldest entry.
- out_payload  output  WIDTH  oldest payload.
- out_rf_we  output  1  oldest entry's register-write flag.
- out_dest  output  5  oldest entry's destination.
- out_result  output  RWIDTH  oldest entry's result.
- flush  input  1  kill all in-flight entries.
- raddr1, raddr2  input  5 each  decode-stage source register numbers.
- fwd_hit1, fwd_hit2  output  1 each  matching in-flight writer found.
- fwd_data1, fwd_data2  output  RWIDTH each  forwarded value.
- hz_stall  output  1  a matching writer's result is not yet ready.
- count  output  CW  number of valid stages.

Behaviour:
- Reset (resetn=0, asynchronous): all stage valid bits and all stored fields clear to 0.
  - Outputs during reset: out_valid=0, count=0, fwd_hit*=0, fwd_data*=0, hz_stall=0, in_ready=1.
- Allow-in chain:
  - allowin[DEPTH-1] = !valid[DEPTH-1] | out_ready.
  - allowin[i] = !valid[i] | allowin[i+1].
  - in_ready = allowin[0]; purely combinational, no dependence on in_valid.
- Advance:
  - Stage i+1 loads stage i's fields when allowin[i+1]; its valid becomes valid[i].
  - Stage 0 loads the in_* fields when allowin[0]; valid[0] <= in_valid.
  - A stage that is not allowed in holds its contents (stall).
  - Fields of an invalid stage are don't-care, but must never produce fwd_hit.
- Throughput and latency:
  - One entry per cycle.
  - Latency from in accept to out_valid is DEPTH-1 cycles after the accepting edge.
  - The entry appears at the oldest stage after DEPTH edges.
- Output: out_* reflect the oldest stage directly. A transfer occurs when out_valid & out_ready.
- Flush:
  - On the next edge all valid bits go to 0.
  - in_valid is ignored that cycle; in_ready is unaffected.
  - An output transfer in the flush cycle is still complete.
  - flush has priority over all advance logic.
- Forwarding lookup (combinational, per port n):
  - Stage i matches when valid[i] & rf_we[i] & dest[i]==raddr_n & raddr_n!=0.
  - Priority goes to the lowest index (youngest).
  - fwd_hit_n=1 on any match; fwd_data_n = result of the prioritised stage, else 0.
  - hz_stall = OR over both ports of (hit & !res_rdy of the prioritised stage).
  - Older matches hidden by a younger match are ignored.
  - raddr=0 never hits.
- Count: registered; count_next = count + (in accept) - (out transfer). Flush forces count to 0 (the out transfer is already accounted for). It never exceeds DEPTH.
- Full condition: all valid and out_ready=0, so in_ready=0. in_ready=1 whenever out_ready=1.
- Reset asserted mid-operation discards all entries immediately; no partial state survives deassertion.

Test Plan:
- Reset then stream: DEPTH=3, out_ready=1, 4 back-to-back entries with dest=1..4 → out_dest 1,2,3,4 appear on cycles 3..6; count stays 3 once full; in_ready=1 throughout.
- Backpressure: out_ready=0 with 5 offered entries → in_ready drops after 3 accepts; count=3. Raising out_ready drains them in order, one per cycle, with no loss or duplication.
- Forward priority:
  - stage0 {dest=5, result=0xAAAA, rdy=1} and stage2 {dest=5, result=0xBBBB}, raddr1=5 → fwd_hit1=1, fwd_data1=0xAAAA.
  - raddr2=0 → fwd_hit2=0.
- Load-use: stage0 {dest=7, we=1, res_rdy=0}, raddr1=7 → hz_stall=1. After the entry advances past with res_rdy still 0, the stall persists until no match remains.
- Flush with output transfer: full pipe, out_ready=1, flush=1, in_valid=1 → exactly one output transfer; next cycle out_valid=0 and count=0; the flush-cycle input is dropped.
- Async reset mid-stream: drop resetn between clock edges with count=2 → out_valid=0 and count=0 before the next edge; the first entry after release emerges normally.
